// File: rtl/nx_indirect_table_pkg.sv
// Shared types and constants for the indirect-access table memory.
package nx_indirect_table_pkg;

    typedef enum logic [1:0] {
        SW_RD  = 2'd0,
        SW_WR  = 2'd1,
        SW_CMP = 2'd2
    } sw_op_e;

    localparam int STARVE_W       = 8;
    localparam int N_IDX_BITS_DEF = 4;

endpackage

// File: rtl/nx_prio_enc_lowest.sv
// Lowest-index priority encoder: reports whether any bit is set and the index
// of the lowest set bit (0 when none).
module nx_prio_enc_lowest #(
    parameter int N  = 32,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  hit,
    output logic          any,
    output logic [IW-1:0] idx
);

    // Scan from the top down so the last assignment is the lowest set bit.
    always_comb begin
        any = |hit;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (hit[i]) begin
                idx = IW'(i);
            end else begin
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/nx_indirect_table_mem.sv
// Flop-based table serving a software (indirect controller) port and a hardware
// port, one access per cycle, with starvation-bounded hardware priority and compare.
module nx_indirect_table_mem
    import nx_indirect_table_pkg::*;
#(
    parameter int                     N_ENTRIES    = 32,
    parameter int                     N_DATA_BITS  = 32,
    parameter int                     N_ADDR_BITS  = 5,
    parameter int                     N_IDX_BITS   = N_IDX_BITS_DEF,
    parameter int                     STARVE_LIMIT = 8,
    parameter logic [N_DATA_BITS-1:0] RESET_DATA   = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sw_cs,
    input  logic                   sw_ce,
    input  logic                   sw_we,
    input  logic [4:0]             sw_add,
    input  logic [N_DATA_BITS-1:0] sw_wdat,
    output logic [N_DATA_BITS-1:0] sw_rdat,
    output logic                   sw_match,
    output logic [N_IDX_BITS-1:0]  sw_aindex,
    output logic                   grant,
    input  logic                   yield,
    input  logic                   hw_req,
    input  logic                   hw_we,
    input  logic [N_ADDR_BITS-1:0] hw_addr,
    input  logic [N_DATA_BITS-1:0] hw_wdat,
    output logic                   hw_ack,
    output logic [N_DATA_BITS-1:0] hw_rdat,
    output logic                   hw_rvld
);

    localparam int ENC_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

    function automatic logic addr_ok(input logic [31:0] a);
        addr_ok = (a < 32'(N_ENTRIES));
    endfunction

    logic [N_DATA_BITS-1:0] mem_r [N_ENTRIES];
    logic [STARVE_W-1:0]    starve_cnt_r;
    logic                   sw_pri_s;
    sw_op_e                 sw_op_s;
    logic                   sw_ok_s;
    logic                   hw_ok_s;
    logic                   sw_wr_s;
    logic                   hw_wr_s;
    logic [N_DATA_BITS-1:0] sw_rd_s;
    logic [N_DATA_BITS-1:0] hw_rd_s;
    logic [N_ENTRIES-1:0]   hit_s;
    logic                   any_s;
    logic [ENC_W-1:0]       enc_idx_s;

    // Arbitration: hardware wins unless software is yielded to or starving.
    always_comb begin
        sw_pri_s = yield | (starve_cnt_r == STARVE_W'(STARVE_LIMIT));
        grant    = sw_cs & (~hw_req | sw_pri_s);
        hw_ack   = hw_req & ~grant;
    end

    // Software op decode and range-qualified read/write selects for both ports.
    always_comb begin
        if (sw_ce) begin
            sw_op_s = SW_CMP;
        end else if (sw_we) begin
            sw_op_s = SW_WR;
        end else begin
            sw_op_s = SW_RD;
        end
        sw_ok_s = addr_ok(32'(sw_add));
        hw_ok_s = addr_ok(32'(hw_addr));
        sw_wr_s = grant & (sw_op_s == SW_WR) & sw_ok_s;
        hw_wr_s = hw_ack & hw_we & hw_ok_s;
        if (sw_ok_s) begin
            sw_rd_s = mem_r[sw_add];
        end else begin
            sw_rd_s = '0;
        end
        if (hw_ok_s) begin
            hw_rd_s = mem_r[hw_addr];
        end else begin
            hw_rd_s = '0;
        end
    end

    // Parallel compare of every entry against the key.
    always_comb begin
        for (int i = 0; i < N_ENTRIES; i++) begin
            hit_s[i] = (mem_r[i] == sw_wdat);
        end
    end

    nx_prio_enc_lowest #(
        .N  (N_ENTRIES),
        .IW (ENC_W)
    ) u_prio_enc (
        .hit (hit_s),
        .any (any_s),
        .idx (enc_idx_s)
    );

    // Table storage; at most one of the two write strobes is active per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                mem_r[i] <= RESET_DATA;
            end
        end else if (sw_wr_s) begin
            mem_r[sw_add] <= sw_wdat;
        end else if (hw_wr_s) begin
            mem_r[hw_addr] <= hw_wdat;
        end
    end

    // Saturating count of consecutive denied software cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= '0;
        end else if (grant || !sw_cs) begin
            starve_cnt_r <= '0;
        end else if (starve_cnt_r != STARVE_W'(STARVE_LIMIT)) begin
            starve_cnt_r <= starve_cnt_r + STARVE_W'(1);
        end
    end

    // Software result registers; compare leaves sw_rdat untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_rdat   <= '0;
            sw_match  <= 1'b0;
            sw_aindex <= '0;
        end else if (grant) begin
            case (sw_op_s)
                SW_RD: begin
                    sw_rdat <= sw_rd_s;
                end
                SW_CMP: begin
                    sw_match  <= any_s;
                    sw_aindex <= N_IDX_BITS'(enc_idx_s);
                end
                default: begin
                    sw_rdat <= sw_rdat;
                end
            endcase
        end
    end

    // Hardware read data and its one-cycle valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hw_rdat <= '0;
            hw_rvld <= 1'b0;
        end else begin
            hw_rvld <= hw_ack & ~hw_we;
            if (hw_ack && !hw_we) begin
                hw_rdat <= hw_rd_s;
            end
        end
    end

endmodule
